// File: rtl/softmax_exp_buffer_pkg.sv
// Shared types and helpers for the softmax exponential buffer.
package softmax_buf_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH  = 10;
  localparam int unsigned DEF_TOTAL_WORDS = 1024;
  localparam int unsigned SUM_WIDTH       = DEF_DATA_WIDTH + DEF_ADDR_WIDTH;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Unsigned add that clamps to all-ones instead of wrapping.
  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [SUM_WIDTH-1:0] b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/softmax_exp_buffer_if.sv
// Input stream from the exp stage and output stream to the divider.
interface softmax_exp_buffer_if
  import softmax_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic                             in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] out_sum;
  logic                             out_last;
  logic                             overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sum, out_last, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sum, out_last, overflow
  );

endinterface

// File: rtl/softmax_exp_buffer_dualport_ram.sv
// Simple dual-port RAM; port-B read data is registered and holds while b_en is low.
module dualport_ram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned TOTAL_WORDS = 1024,
  parameter string       RAM_STYLE   = "block"
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  logic [DATA_WIDTH-1:0] mem [TOTAL_WORDS];

  // Writes from either port.
  always_ff @(posedge clk) begin
    if (a_en && a_we) mem[a_addr] <= a_wdata;
    if (b_en && b_we) mem[b_addr] <= b_wdata;
  end

  if (RAM_STYLE == "block") begin : g_block
    logic [DATA_WIDTH-1:0] rdata_q;
    // Synchronous read into an output register.
    always_ff @(posedge clk) begin
      if (b_en) rdata_q <= mem[b_addr];
    end
    assign b_rdata = rdata_q;
  end else begin : g_dist
    logic [ADDR_WIDTH-1:0] raddr_q;
    // Registered address with asynchronous array read.
    always_ff @(posedge clk) begin
      if (b_en) raddr_q <= b_addr;
    end
    assign b_rdata = mem[raddr_q];
  end

endmodule

// File: rtl/softmax_exp_buffer.sv
// Buffers one vector of exp values with its running sum, then replays it to the divider.
// Optional: SOFTMAX_BUF_SATURATE_EN makes the sum accumulator saturate instead of wrap.
module softmax_exp_buffer
  import softmax_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned TOTAL_WORDS = DEF_TOTAL_WORDS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  softmax_exp_buffer_if.slave  bus
);

  localparam int unsigned SUM_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] FULL_ADDR = ADDR_WIDTH'(TOTAL_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  in_ready_q, in_ready_d;
  logic                  overflow_q, overflow_d;

  logic                  ram_a_en;
  logic                  ram_b_en;
  logic [DATA_WIDTH-1:0] ram_b_rdata;
  logic [SUM_W-1:0]      sum_add;

  // Accumulator step for the incoming element.
  always_comb begin
`ifdef SOFTMAX_BUF_SATURATE_EN
    sum_add = SUM_W'(sat_add(SUM_WIDTH'(sum_q), SUM_WIDTH'(bus.in_data)));
`else
    sum_add = sum_q + SUM_W'(bus.in_data);
`endif
  end

  // Next-state, counter and RAM-enable logic.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    last_addr_d = last_addr_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    overflow_d  = overflow_q;
    ram_a_en    = 1'b0;
    ram_b_en    = 1'b0;

    case (state_q)
      FILL: begin
        if (bus.in_valid && in_ready_q) begin
          ram_a_en  = 1'b1;
          sum_d     = sum_add;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          if (bus.in_last || (wr_addr_q == FULL_ADDR)) begin
            state_d     = DRAIN;
            last_addr_d = wr_addr_q;
            in_ready_d  = 1'b0;
            if (!bus.in_last) overflow_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          state_d     = FILL;
          in_ready_d  = 1'b1;
          rd_addr_d   = '0;
          wr_addr_d   = '0;
          sum_d       = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
          // Refill the output slot whenever it is free or being emptied.
          if ((rd_addr_q <= CNT_W'(last_addr_q)) && (!out_valid_q || bus.out_ready)) begin
            ram_b_en    = 1'b1;
            rd_addr_d   = rd_addr_q + CNT_W'(1);
            out_valid_d = 1'b1;
            out_last_d  = (rd_addr_q == CNT_W'(last_addr_q));
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FILL;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      last_addr_q <= last_addr_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      overflow_q  <= overflow_d;
    end
  end

  dualport_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TOTAL_WORDS(TOTAL_WORDS),
    .RAM_STYLE  ("block")
  ) u_ram (
    .clk    (clock),
    .a_en   (ram_a_en),
    .a_we   (ram_a_en),
    .a_addr (wr_addr_q),
    .a_wdata(bus.in_data),
    .b_en   (ram_b_en),
    .b_we   (1'b0),
    .b_addr (rd_addr_q[ADDR_WIDTH-1:0]),
    .b_wdata('0),
    .b_rdata(ram_b_rdata)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = ram_b_rdata;
  assign bus.out_sum   = sum_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_softmax_exp_buffer.sv
// Directed testbench for softmax_exp_buffer.
module tb_softmax_exp_buffer;
  import softmax_buf_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned TW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_exp_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  softmax_exp_buffer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TOTAL_WORDS(TW)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] vec[$];
  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [63:0] cap_sum;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer vec as one vector; in_last on the final element.
  task automatic send();
    int idx = 0;
    int guard = 0;
    while (idx < vec.size() && guard < 5000) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vec[idx];
      bus.in_last  = (idx == vec.size() - 1);
      if (bus.in_ready) idx++;
      guard++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("send_accepted", 64'(idx), 64'(vec.size()));
    chk("in_ready_in_drain", 64'(bus.in_ready), 64'd0);
  endtask

  // Collect n outputs; toggle selects out_ready pattern 1,0,0,1 repeating.
  task automatic collect(input int n, input bit toggle);
    int k = 0;
    bit held = 1'b0;
    bit have_sum = 1'b0;
    logic [31:0] hd = '0;
    logic hl = 1'b0;
    logic rdy;
    got_d.delete();
    got_l.delete();
    cap_sum = '0;
    while (got_d.size() < n && k < 4 * n + 20) begin
      @(negedge clk);
      rdy = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      bus.out_ready = rdy;
      if (held) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", 64'(bus.out_data), 64'(hd));
        chk("stall_last", 64'(bus.out_last), 64'(hl));
      end
      if (bus.out_valid && !have_sum) begin
        cap_sum  = 64'(bus.out_sum);
        have_sum = 1'b1;
      end
      if (bus.out_valid && rdy) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
      held = bus.out_valid && !rdy;
      hd   = bus.out_data;
      hl   = bus.out_last;
      k++;
    end
    chk("out_count", 64'(got_d.size()), 64'(n));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  // Compare collected outputs against vec, out_last only on the final one.
  task automatic check_vec(input string tag);
    for (int i = 0; i < got_d.size() && i < vec.size(); i++) begin
      chk({tag, "_data"}, 64'(got_d[i]), 64'(vec[i]));
      chk({tag, "_last"}, 64'(got_l[i]), 64'(i == vec.size() - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 1,2,3,4 with out_ready high
    vec = '{32'd1, 32'd2, 32'd3, 32'd4};
    send();
    collect(4, 1'b0);
    chk("v1_sum", cap_sum, 64'd10);
    check_vec("v1");
    @(negedge clk);
    chk("v1_in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("v1_overflow", 64'(bus.overflow), 64'd0);

    // Same vector with out_ready toggling
    send();
    collect(4, 1'b1);
    chk("v2_sum", cap_sum, 64'd10);
    check_vec("v2");
    @(negedge clk);
    chk("v2_in_ready_after", 64'(bus.in_ready), 64'd1);

    // Length-1 vector at the data maximum
    vec = '{32'hFFFF_FFFF};
    send();
    collect(1, 1'b0);
    chk("v3_sum", cap_sum, 64'h00_FFFF_FFFF);
    check_vec("v3");

    // in_valid held high through DRAIN
    vec = '{32'd7, 32'd8};
    send();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD;
    bus.in_last  = 1'b0;
    collect(2, 1'b0);
    chk("v4_sum", cap_sum, 64'd15);
    check_vec("v4");
    vec = '{32'hDEAD, 32'd9};
    send();
    collect(2, 1'b0);
    chk("v5_sum", cap_sum, 64'hDEB6);
    check_vec("v5");

    // Overflow: TW+3 values, no in_last
    acc = 0;
    for (int g = 0; g < 3 * TW && acc < TW; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(acc);
      bus.in_last  = 1'b0;
      if (bus.in_ready) acc++;
    end
    chk("ovf_accepted", 64'(acc), 64'(TW));
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(TW + e);
      chk("ovf_excess_stalled", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    vec.delete();
    for (int i = 0; i < TW; i++) vec.push_back(32'(i));
    collect(TW, 1'b0);
    chk("ovf_sum", cap_sum, 64'd523776);
    check_vec("ovf");
    @(negedge clk);
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    chk("ovf_in_ready_after", 64'(bus.in_ready), 64'd1);

    // Reset mid-DRAIN after two of four outputs
    vec = '{32'd1, 32'd2, 32'd3, 32'd4};
    send();
    collect(2, 1'b0);
    chk("mid_d0", 64'(got_d[0]), 64'd1);
    chk("mid_d1", 64'(got_d[1]), 64'd2);
    @(negedge clk);
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_overflow", 64'(bus.overflow), 64'd0);
    chk("async_rst_sum", 64'(bus.out_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    vec = '{32'd5, 32'd6};
    send();
    collect(2, 1'b0);
    chk("v6_sum", cap_sum, 64'd11);
    check_vec("v6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
